router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
- Ingress controller for the 3-output router. Accepts byte-serial packets on one input port, decodes the destination from the header, and sequences writes into three downstream packet FIFOs.
- Drives each FIFO's write_enb, lfd_state and datain, and applies backpressure to the sender through busy.
- Checks packet parity and generates per-FIFO soft_reset when a consumer stops reading.

Parameters:
- TIMEOUT, 30, consecutive cycles a non-empty FIFO may go unread before that FIFO's soft_reset pulses.
- NUM_PORTS, 3, number of output FIFOs; fixed at 3 because the address field is 2 bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- pkt_valid  in  1  high from the header byte through the parity byte inclusive
- data_in  in  8  packet byte; header is [7:2]=payload length, [1:0]=destination
- busy  out  1  sender must hold data_in/pkt_valid while high
- fifo_full  in  3  per-FIFO full
- fifo_empty  in  3  per-FIFO empty
- read_enb  in  3  per-FIFO read strobe from the consumers
- write_enb  out  3  one-hot FIFO write strobe
- lfd_state  out  1  header marker, high the cycle before the header write
- data_out  out  8  byte to the FIFO datain
- soft_reset  out  3  per-FIFO flush pulse
- err  out  1  parity mismatch on the last packet

Behaviour:
- Accept rule: a byte is accepted when pkt_valid && !busy. Every accepted byte goes into pipe_reg (data_out) and sets wr_pend.
- Write timing: write_enb = wr_pend ? onehot(dest) : 0. A write completes on the first cycle where wr_pend && !fifo_full[dest]; wr_pend then clears, unless a new byte is accepted in the same cycle.
- Latency: data_in to FIFO write is 1 cycle minimum.
- Busy conditions: busy is high when any of the following holds.
  - wr_pend && fifo_full[dest]
  - state is WAIT_EMPTY or CHECK_PARITY
- FSM states, reset to DECODE:
  - DECODE: on pkt_valid, latch dest = data_in[1:0] and len = data_in[7:2], and clear parity_acc.
    - dest==3 or len==0: go to DROP, nothing written.
    - fifo_empty[dest]==0: latch the header, go to WAIT_EMPTY.
    - Otherwise: accept the header, lfd_state=1, parity_acc=header, go to LOAD_DATA.
  - WAIT_EMPTY: when fifo_empty[dest], lfd_state=1, set wr_pend with the held header, go to LOAD_DATA.
  - LOAD_DATA: each accepted byte XORs into parity_acc and decrements len. When the byte that takes len to 0 is accepted, go to LOAD_PARITY.
  - LOAD_PARITY: accept the parity byte (it is written to the FIFO) and latch it into par_rx, go to CHECK_PARITY.
  - CHECK_PARITY: wait until wr_pend==0. Then err <= (parity_acc != par_rx), go to DECODE.
  - DROP: consume bytes (busy=0, no writes) until pkt_valid==0, then go to DECODE.
- Framing errors:
  - If pkt_valid drops in LOAD_DATA or LOAD_PARITY: set err=1, abandon the packet, go to DECODE.
  - Extra bytes after parity with pkt_valid still high are treated as a new header.
- err behaviour: holds its value until the next header is accepted, which clears it.
- Soft reset, per FIFO i:
  - Counter increments while !fifo_empty[i] && !read_enb[i]; it clears on read_enb[i] or when empty.
  - On reaching TIMEOUT-1: soft_reset[i]=1 for exactly one cycle, and the counter clears.
- Soft reset during an active packet (soft_reset[dest] in WAIT_EMPTY, LOAD_DATA, LOAD_PARITY or CHECK_PARITY):
  - Clear wr_pend; err is not set.
  - Go to DROP if pkt_valid, else DECODE.
- Reset values: write_enb=0, lfd_state=0, busy=0, data_out=0, soft_reset=0, err=0; all counters 0.
- Simultaneous events: soft_reset has priority over a write completion in the same cycle. read_enb and the timeout in the same cycle means no pulse.

Optional Feature:
- Macro: ROUTER_DROP_CNT_EN.
- When defined: adds output drop_cnt[7:0]. It increments, saturating at 255, on each entry to DROP (invalid address, zero length, or soft-reset abort). Reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg holds:
  - state enum: DECODE, WAIT_EMPTY, LOAD_DATA, LOAD_PARITY, CHECK_PARITY, DROP
  - ADDR_INVALID=2'd3
  - header field positions (LEN_MSB=7, LEN_LSB=2)
- Sub-module router_sreset_timer: one FIFO's timeout counter and pulse, instantiated NUM_PORTS times.

Test Plan:
- Header 0x0D (len 3, dest 1), 3 payload bytes, correct parity, all FIFOs empty -> lfd_state high 1 cycle, then write_enb=3'b010 for 5 consecutive cycles, err=0.
- Same packet with parity byte XOR 0x01 -> identical writes, err=1 after CHECK_PARITY; next header accepted -> err=0.
- Header 0x07 (dest 3) with 2 more bytes -> no write_enb, busy stays 0, DECODE after pkt_valid falls; drop_cnt=1 when ROUTER_DROP_CNT_EN.
- fifo_empty[0]=0 when header 0x04 arrives -> busy high; fifo_empty[0] rises -> lfd_state next cycle, header written.
- fifo_full[2] raised mid-payload for 4 cycles -> busy high exactly those cycles; the pending byte is held on data_out, no byte is lost, and the byte order in the FIFO is preserved.
- FIFO 0 non-empty with read_enb[0]=0 for 30 cycles -> soft_reset[0] single pulse on cycle 30. A read at cycle 29 -> no pulse, counter restarts.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress controller.
// The optional drop counter is enabled with `define ROUTER_DROP_CNT_EN.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE,
        WAIT_EMPTY,
        LOAD_DATA,
        LOAD_PARITY,
        CHECK_PARITY,
        DROP
    } state_t;

    localparam int          NUM_PORTS    = 3;
    localparam logic [1:0]  ADDR_INVALID = 2'd3;
    localparam int          LEN_MSB      = 7;
    localparam int          LEN_LSB      = 2;

    // Address 3 has no FIFO, so it maps to an all-zero strobe.
    function automatic logic [NUM_PORTS-1:0] dest_onehot(input logic [1:0] d);
        logic [NUM_PORTS-1:0] oh;
        case (d)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/router_sreset_timer.sv
// Per-FIFO stall timer: pulses o_soft_reset for one cycle when a non-empty
// FIFO has gone unread for TIMEOUT consecutive cycles.
module router_sreset_timer #(
    parameter int TIMEOUT = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic i_fifo_empty,
    input  logic i_read_enb,
    output logic o_soft_reset
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_stall;
    logic          w_hit;

    assign w_stall = !i_fifo_empty && !i_read_enb;
    // A read in the timeout cycle removes the stall, so no pulse is produced.
    assign w_hit   = w_stall && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!w_stall || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_soft_reset = w_hit;

endmodule

// File: rtl/router_ctrl.sv
// Router ingress controller: header decode, FIFO write sequencing, parity
// check and stall flush. `define ROUTER_DROP_CNT_EN adds the drop_cnt output.
module router_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pkt_valid,
    input  logic [7:0]           data_in,
    output logic                 busy,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 lfd_state,
    output logic [7:0]           data_out,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic                 err,
`ifdef ROUTER_DROP_CNT_EN
    output logic [7:0]           drop_cnt,
`endif
    output state_t               dbg_state
);

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_dest, w_dest_nxt;
    logic [5:0]           r_len, w_len_nxt;
    logic [7:0]           r_acc, w_acc_nxt;
    logic [7:0]           r_par_rx, w_par_nxt;
    logic [7:0]           r_pipe, w_pipe_nxt;
    logic                 r_wr_pend, w_wr_pend_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_lfd;
    logic                 w_drop_entry;
    logic                 w_accept;
    logic                 w_active;
    logic [NUM_PORTS-1:0] w_dest_oh;
    logic [NUM_PORTS-1:0] w_hdr_oh;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
        router_sreset_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clk          (clk),
            .reset        (reset),
            .i_fifo_empty (fifo_empty[i]),
            .i_read_enb   (read_enb[i]),
            .o_soft_reset (soft_reset[i])
        );
    end

    assign w_dest_oh = dest_onehot(r_dest);
    assign w_hdr_oh  = dest_onehot(data_in[1:0]);
    assign busy      = (r_wr_pend && |(fifo_full & w_dest_oh))
                     || (r_state == WAIT_EMPTY) || (r_state == CHECK_PARITY);
    assign w_accept  = pkt_valid && !busy;
    assign w_active  = (r_state == WAIT_EMPTY) || (r_state == LOAD_DATA)
                     || (r_state == LOAD_PARITY) || (r_state == CHECK_PARITY);

    always_comb begin
        w_state_nxt   = r_state;
        w_dest_nxt    = r_dest;
        w_len_nxt     = r_len;
        w_acc_nxt     = r_acc;
        w_par_nxt     = r_par_rx;
        w_pipe_nxt    = r_pipe;
        w_err_nxt     = r_err;
        w_lfd         = 1'b0;
        w_drop_entry  = 1'b0;
        // A pending byte stays pending only while its FIFO is full.
        w_wr_pend_nxt = r_wr_pend && |(fifo_full & w_dest_oh);

        if (w_active && |(soft_reset & w_dest_oh)) begin
            w_wr_pend_nxt = 1'b0;
            if (pkt_valid) begin
                w_state_nxt  = DROP;
                w_drop_entry = 1'b1;
            end else begin
                w_state_nxt  = DECODE;
            end
        end else begin
            case (r_state)
                DECODE: begin
                    if (pkt_valid) begin
                        w_dest_nxt = data_in[1:0];
                        w_len_nxt  = data_in[LEN_MSB:LEN_LSB];
                        w_acc_nxt  = '0;
                        if (data_in[1:0] == ADDR_INVALID || data_in[LEN_MSB:LEN_LSB] == '0) begin
                            w_state_nxt  = DROP;
                            w_drop_entry = 1'b1;
                        end else if (!(|(fifo_empty & w_hdr_oh))) begin
                            w_pipe_nxt  = data_in;
                            w_err_nxt   = 1'b0;
                            w_state_nxt = WAIT_EMPTY;
                        end else begin
                            w_pipe_nxt    = data_in;
                            w_wr_pend_nxt = 1'b1;
                            w_lfd         = 1'b1;
                            w_acc_nxt     = data_in;
                            w_err_nxt     = 1'b0;
                            w_state_nxt   = LOAD_DATA;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    if (|(fifo_empty & w_dest_oh)) begin
                        w_lfd         = 1'b1;
                        w_wr_pend_nxt = 1'b1;
                        w_acc_nxt     = r_pipe;
                        w_state_nxt   = LOAD_DATA;
                    end
                end
                LOAD_DATA: begin
                    if (!pkt_valid) begin
                        w_err_nxt     = 1'b1;
                        w_wr_pend_nxt = 1'b0;
                        w_state_nxt   = DECODE;
                    end else if (w_accept) begin
                        w_pipe_nxt    = data_in;
                        w_wr_pend_nxt = 1'b1;
                        w_acc_nxt     = r_acc ^ data_in;
                        w_len_nxt     = r_len - 6'd1;
                        if (r_len == 6'd1) begin
                            w_state_nxt = LOAD_PARITY;
                        end
                    end
                end
                LOAD_PARITY: begin
                    if (!pkt_valid) begin
                        w_err_nxt     = 1'b1;
                        w_wr_pend_nxt = 1'b0;
                        w_state_nxt   = DECODE;
                    end else if (w_accept) begin
                        w_pipe_nxt    = data_in;
                        w_wr_pend_nxt = 1'b1;
                        w_par_nxt     = data_in;
                        w_state_nxt   = CHECK_PARITY;
                    end
                end
                CHECK_PARITY: begin
                    if (!r_wr_pend) begin
                        w_err_nxt   = (r_acc != r_par_rx);
                        w_state_nxt = DECODE;
                    end
                end
                DROP: begin
                    if (!pkt_valid) begin
                        w_state_nxt = DECODE;
                    end
                end
                default: w_state_nxt = DECODE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= DECODE;
            r_dest    <= '0;
            r_len     <= '0;
            r_acc     <= '0;
            r_par_rx  <= '0;
            r_pipe    <= '0;
            r_wr_pend <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dest    <= w_dest_nxt;
            r_len     <= w_len_nxt;
            r_acc     <= w_acc_nxt;
            r_par_rx  <= w_par_nxt;
            r_pipe    <= w_pipe_nxt;
            r_wr_pend <= w_wr_pend_nxt;
            r_err     <= w_err_nxt;
        end
    end

`ifdef ROUTER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop_entry && r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign write_enb = r_wr_pend ? w_dest_oh : '0;
    assign lfd_state = w_lfd;
    assign data_out  = r_pipe;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: inputs change on the falling edge, outputs
// are sampled 1 ns later; completed FIFO writes are scored against exp_q.
module tb_router_ctrl;
    import router_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       busy;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] data_out;
    logic [2:0] soft_reset;
    logic       err;
    state_t     dbg_state;
`ifdef ROUTER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    router_ctrl #(.TIMEOUT(30)) dut (
        .clk        (clk),
        .reset      (reset),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_out   (data_out),
        .soft_reset (soft_reset),
        .err        (err),
`ifdef ROUTER_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive all inputs on the falling edge, then record any
    // write that will complete on the coming rising edge.
    task automatic step(input logic v, input logic [7:0] d,
                        input logic [2:0] full = 3'b000,
                        input logic [2:0] empty = 3'b111,
                        input logic [2:0] rd = 3'b000);
        @(negedge clk);
        pkt_valid  = v;
        data_in    = d;
        fifo_full  = full;
        fifo_empty = empty;
        read_enb   = rd;
        #1;
        if ((write_enb & ~fifo_full) != 3'b000) got_q.push_back({write_enb, data_out});
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        step(1'b1, b);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            step(1'b1, b);
            n++;
        end
        chk("send_hold_bound", 32'(n < 64), 32'd1);
    endtask

    task automatic push_exp(input logic [2:0] oh, input logic [7:0] b);
        exp_q.push_back({oh, b});
    endtask

    task automatic check_sb(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk(tag, got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        reset      = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_write_enb", write_enb, 3'b000);
        chk("rst_lfd", lfd_state, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_soft_reset", soft_reset, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_state", dbg_state, DECODE);
`ifdef ROUTER_DROP_CNT_EN
        chk("rst_drop_cnt", drop_cnt, 8'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Good packet to FIFO 1: header 0x0D, payload 11 22 33, parity 0x0D.
        step(1'b1, 8'h0D);
        chk("t1_lfd_hdr", lfd_state, 1'b1);
        chk("t1_we_hdr", write_enb, 3'b000);
        chk("t1_busy_hdr", busy, 1'b0);
        step(1'b1, 8'h11);
        chk("t1_lfd_off", lfd_state, 1'b0);
        chk("t1_we1", write_enb, 3'b010);
        chk("t1_do1", data_out, 8'h0D);
        step(1'b1, 8'h22);
        chk("t1_we2", write_enb, 3'b010);
        chk("t1_do2", data_out, 8'h11);
        step(1'b1, 8'h33);
        chk("t1_we3", write_enb, 3'b010);
        step(1'b1, 8'h0D);
        chk("t1_we4", write_enb, 3'b010);
        chk("t1_st_par", dbg_state, LOAD_PARITY);
        step(1'b0, 8'h00);
        chk("t1_we5", write_enb, 3'b010);
        chk("t1_do5", data_out, 8'h0D);
        chk("t1_busy_chk", busy, 1'b1);
        step(1'b0, 8'h00);
        chk("t1_we_done", write_enb, 3'b000);
        chk("t1_busy_chk2", busy, 1'b1);
        step(1'b0, 8'h00);
        chk("t1_err", err, 1'b0);
        chk("t1_state", dbg_state, DECODE);
        chk("t1_busy_idle", busy, 1'b0);
        push_exp(3'b010, 8'h0D); push_exp(3'b010, 8'h11); push_exp(3'b010, 8'h22);
        push_exp(3'b010, 8'h33); push_exp(3'b010, 8'h0D);
        check_sb("t1_sb");

        // Same packet with a corrupted parity byte, then a clean one.
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0C);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("t2_err_set", err, 1'b1);
        send(8'h0D);
        chk("t2_err_held", err, 1'b1);
        send(8'h11);
        chk("t2_err_clear", err, 1'b0);
        send(8'h22); send(8'h33); send(8'h0D);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("t2_err_good", err, 1'b0);
        push_exp(3'b010, 8'h0D); push_exp(3'b010, 8'h11); push_exp(3'b010, 8'h22);
        push_exp(3'b010, 8'h33); push_exp(3'b010, 8'h0C);
        push_exp(3'b010, 8'h0D); push_exp(3'b010, 8'h11); push_exp(3'b010, 8'h22);
        push_exp(3'b010, 8'h33); push_exp(3'b010, 8'h0D);
        check_sb("t2_sb");

        // Invalid address 3: dropped without writes or backpressure.
        step(1'b1, 8'h07);
        chk("t3_busy0", busy, 1'b0);
        chk("t3_we0", write_enb, 3'b000);
        step(1'b1, 8'hAA);
        chk("t3_state_drop", dbg_state, DROP);
        chk("t3_busy1", busy, 1'b0);
        chk("t3_we1", write_enb, 3'b000);
        step(1'b1, 8'hBB);
        chk("t3_busy2", busy, 1'b0);
        step(1'b0, 8'h00);
        chk("t3_still_drop", dbg_state, DROP);
        step(1'b0, 8'h00);
        chk("t3_state_decode", dbg_state, DECODE);
`ifdef ROUTER_DROP_CNT_EN
        chk("t3_drop_cnt", drop_cnt, 8'd1);
`endif
        check_sb("t3_sb");

        // pkt_valid falls mid-payload: framing error.
        step(1'b1, 8'h0D);
        step(1'b1, 8'h11);
        step(1'b0, 8'h00);
        chk("tf_we_pend", write_enb, 3'b010);
        chk("tf_do_pend", data_out, 8'h11);
        step(1'b0, 8'h00);
        chk("tf_err", err, 1'b1);
        chk("tf_state", dbg_state, DECODE);
        chk("tf_we_off", write_enb, 3'b000);
        push_exp(3'b010, 8'h0D); push_exp(3'b010, 8'h11);
        check_sb("tf_sb");

        // FIFO 0 not empty at header 0x04: wait, then header written.
        step(1'b1, 8'h04, 3'b000, 3'b110);
        chk("t4_busy_hdr", busy, 1'b0);
        chk("t4_lfd_hdr", lfd_state, 1'b0);
        step(1'b1, 8'h5A, 3'b000, 3'b110);
        chk("t4_state_wait", dbg_state, WAIT_EMPTY);
        chk("t4_busy_wait", busy, 1'b1);
        chk("t4_we_wait", write_enb, 3'b000);
        chk("t4_err_cleared", err, 1'b0);
        step(1'b1, 8'h5A, 3'b000, 3'b110);
        chk("t4_busy_wait2", busy, 1'b1);
        step(1'b1, 8'h5A);
        chk("t4_lfd", lfd_state, 1'b1);
        chk("t4_we_lfd", write_enb, 3'b000);
        step(1'b1, 8'h5A);
        chk("t4_busy_run", busy, 1'b0);
        chk("t4_we_hdr", write_enb, 3'b001);
        chk("t4_do_hdr", data_out, 8'h04);
        step(1'b1, 8'h5E);
        chk("t4_do_pay", data_out, 8'h5A);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("t4_err", err, 1'b0);
        chk("t4_state", dbg_state, DECODE);
        push_exp(3'b001, 8'h04); push_exp(3'b001, 8'h5A); push_exp(3'b001, 8'h5E);
        check_sb("t4_sb");

        // FIFO 2 full for 4 cycles mid-payload.
        step(1'b1, 8'h12);
        step(1'b1, 8'hA1);
        chk("t5_busy_pre", busy, 1'b0);
        chk("t5_we_pre", write_enb, 3'b100);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hA2, 3'b100);
            chk("t5_busy_full", busy, 1'b1);
            chk("t5_do_held", data_out, 8'hA1);
        end
        step(1'b1, 8'hA2);
        chk("t5_busy_release", busy, 1'b0);
        chk("t5_do_release", data_out, 8'hA1);
        step(1'b1, 8'hA3);
        chk("t5_busy_a3", busy, 1'b0);
        chk("t5_do_a2", data_out, 8'hA2);
        step(1'b1, 8'hA4);
        chk("t5_do_a3", data_out, 8'hA3);
        step(1'b1, 8'h16);
        chk("t5_busy_par", busy, 1'b0);
        chk("t5_do_a4", data_out, 8'hA4);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("t5_err", err, 1'b0);
        chk("t5_state", dbg_state, DECODE);
        push_exp(3'b100, 8'h12); push_exp(3'b100, 8'hA1); push_exp(3'b100, 8'hA2);
        push_exp(3'b100, 8'hA3); push_exp(3'b100, 8'hA4); push_exp(3'b100, 8'h16);
        check_sb("t5_sb");

        // FIFO 0 unread for 30 cycles: one pulse on cycle 30.
        for (int i = 1; i <= 29; i++) begin
            step(1'b0, 8'h00, 3'b000, 3'b110);
            chk("t6_no_pulse", soft_reset, 3'b000);
        end
        step(1'b0, 8'h00, 3'b000, 3'b110);
        chk("t6_pulse", soft_reset, 3'b001);
        step(1'b0, 8'h00, 3'b000, 3'b110);
        chk("t6_pulse_once", soft_reset, 3'b000);
        step(1'b0, 8'h00);

        // Read on cycle 29 restarts the count.
        for (int i = 1; i <= 28; i++) step(1'b0, 8'h00, 3'b000, 3'b110);
        step(1'b0, 8'h00, 3'b000, 3'b110, 3'b001);
        chk("t6_read29", soft_reset, 3'b000);
        for (int i = 30; i <= 58; i++) begin
            step(1'b0, 8'h00, 3'b000, 3'b110);
            chk("t6_restart_no_pulse", soft_reset, 3'b000);
        end
        step(1'b0, 8'h00, 3'b000, 3'b110);
        chk("t6_restart_pulse", soft_reset, 3'b001);
        step(1'b0, 8'h00);

        // Read in the timeout cycle itself suppresses the pulse.
        for (int i = 1; i <= 29; i++) step(1'b0, 8'h00, 3'b000, 3'b110);
        step(1'b0, 8'h00, 3'b000, 3'b110, 3'b001);
        chk("t6_read30", soft_reset, 3'b000);
        step(1'b0, 8'h00);

        // Soft reset while waiting for FIFO 0 aborts into DROP.
        step(1'b1, 8'h04, 3'b000, 3'b110);
        for (int i = 2; i <= 29; i++) step(1'b1, 8'h5A, 3'b000, 3'b110);
        chk("t7_wait", dbg_state, WAIT_EMPTY);
        step(1'b1, 8'h5A, 3'b000, 3'b110);
        chk("t7_pulse", soft_reset, 3'b001);
        chk("t7_busy_pulse", busy, 1'b1);
        step(1'b1, 8'h5A);
        chk("t7_state_drop", dbg_state, DROP);
        chk("t7_busy_drop", busy, 1'b0);
        chk("t7_we_drop", write_enb, 3'b000);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("t7_state_decode", dbg_state, DECODE);
        chk("t7_err", err, 1'b0);
`ifdef ROUTER_DROP_CNT_EN
        chk("t7_drop_cnt", drop_cnt, 8'd2);
`endif
        check_sb("t7_sb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
